// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared types and width helpers for the N x M crossbar.
//   cmd_e          master/slave command encoding (read / write)
//   slave_state_e  per-slave grant FSM state
//   sel_w()        width of the slave-select field taken from the top address bits
//   mid_w()        width of a master index (owner / round-robin pointer)
package crossbar_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slave_state_e;

  function automatic int sel_w(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

  function automatic int mid_w(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/crossbar_slave_port.sv
// crossbar_slave_port: arbitration and return tracking for one slave port.
//   clock, reset  rising-edge clock, synchronous active-low reset
//   cand_i        masters currently eligible for this slave (req, decoded here, unowned)
//   slave_ack_i   acceptance pulse from the slave
//   owner_cmd_i   command of the current owner (decides whether a return follows)
//   busy_o        slave is serving owner_o
//   owner_o       master index currently granted
//   rd_pend_o     a read response is on slave_rdata this cycle
//   rd_owner_o    master that the pending read response belongs to
module crossbar_slave_port
  import crossbar_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = mid_w(NUM_MASTERS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] cand_i,
  input  logic                   slave_ack_i,
  input  logic                   owner_cmd_i,
  output logic                   busy_o,
  output logic [MID_W-1:0]       owner_o,
  output logic                   rd_pend_o,
  output logic [MID_W-1:0]       rd_owner_o
);

  slave_state_e     state_q, state_d;
  logic [MID_W-1:0] owner_q, owner_d;
  logic [MID_W-1:0] ptr_q, ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [MID_W-1:0] rd_owner_q, rd_owner_d;
  logic [MID_W-1:0] pick;

  // (base + offset) modulo NUM_MASTERS; NUM_MASTERS need not be a power of two.
  function automatic logic [MID_W-1:0] rr_index(input logic [MID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_MASTERS) sum -= NUM_MASTERS;
    return MID_W'(sum);
  endfunction

  // Scan from the farthest slot back to ptr so the last hit is the first
  // candidate at or after ptr.
  always_comb begin
    pick = ptr_q;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (cand_i[rr_index(ptr_q, k)]) pick = rr_index(ptr_q, k);
    end
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    case (state_q)
      IDLE: begin
        if (|cand_i) begin
          state_d = BUSY;
          owner_d = pick;
        end
      end
      BUSY: begin
        if (slave_ack_i) begin
          state_d = IDLE;
          ptr_d   = rr_index(owner_q, 1);
          if (owner_cmd_i == CMD_READ) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign busy_o     = (state_q == BUSY);
  assign owner_o    = owner_q;
  assign rd_pend_o  = rd_pend_q;
  assign rd_owner_o = rd_owner_q;

endmodule

// File: rtl/crossbar_nxm.sv
// crossbar_nxm: N-master x M-slave request/acknowledge crossbar.
//   clock, reset        rising-edge clock, synchronous active-low reset
//   master_req/cmd      per-master request and command (0 read, 1 write)
//   master_addr/wdata   packed per-master address and write data
//   master_ack          one-cycle acceptance pulse back to the owning master
//   master_rdata        read data, one cycle after the read was acknowledged
//   slave_req/cmd       forwarded request and command per slave
//   slave_addr/wdata    forwarded full address and write data per slave
//   slave_ack           slave acceptance pulse
//   slave_rdata         slave read data, one cycle after a read acknowledge
// The top address bits select the slave; each slave has its own arbiter.
module crossbar_nxm
  import crossbar_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        master_req,
  input  logic [NUM_MASTERS-1:0]        master_cmd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] master_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] master_wdata,
  output logic [NUM_MASTERS-1:0]        master_ack,
  output logic [NUM_MASTERS*DATA_W-1:0] master_rdata,
  output logic [NUM_SLAVES-1:0]         slave_req,
  output logic [NUM_SLAVES-1:0]         slave_cmd,
  output logic [NUM_SLAVES*ADDR_W-1:0]  slave_addr,
  output logic [NUM_SLAVES*DATA_W-1:0]  slave_wdata,
  input  logic [NUM_SLAVES-1:0]         slave_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0]  slave_rdata
);

  localparam int SelW = sel_w(NUM_SLAVES);
  localparam int MidW = mid_w(NUM_MASTERS);

  logic [SelW-1:0]        tgt       [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] owned;
  logic [NUM_MASTERS-1:0] cand      [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]  busy;
  logic [NUM_SLAVES-1:0]  rd_pend;
  logic [NUM_SLAVES-1:0]  owner_cmd;
  logic [MidW-1:0]        owner     [NUM_SLAVES];
  logic [MidW-1:0]        rd_owner  [NUM_SLAVES];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      tgt[i] = master_addr[i*ADDR_W + ADDR_W - 1 -: SelW];
    end
  end

  // Masters already held by a busy slave are withheld from every arbiter.
  always_comb begin
    owned = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (busy[s] && owner[s] == MidW'(i)) owned[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SLAVES; s++) begin
      cand[s] = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cand[s][i] = master_req[i] && (tgt[i] == SelW'(s)) && !owned[i];
      end
    end
  end

  always_comb begin
    owner_cmd = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (owner[s] == MidW'(i)) owner_cmd[s] = master_cmd[i];
      end
    end
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    crossbar_slave_port #(
      .NUM_MASTERS (NUM_MASTERS),
      .MID_W       (MidW)
    ) u_port (
      .clock       (clock),
      .reset       (reset),
      .cand_i      (cand[s]),
      .slave_ack_i (slave_ack[s]),
      .owner_cmd_i (owner_cmd[s]),
      .busy_o      (busy[s]),
      .owner_o     (owner[s]),
      .rd_pend_o   (rd_pend[s]),
      .rd_owner_o  (rd_owner[s])
    );
  end

  // Forwarding muxes plus OR-reduction of per-slave ack/rdata contributions.
  // Outputs are forced to zero while reset is low so a late slave_ack or a
  // pending return never reaches a master during reset.
  always_comb begin
    slave_req    = '0;
    slave_cmd    = '0;
    slave_addr   = '0;
    slave_wdata  = '0;
    master_ack   = '0;
    master_rdata = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (busy[s] && owner[s] == MidW'(i)) begin
          slave_req[s]                         = 1'b1;
          slave_cmd[s]                         = master_cmd[i];
          slave_addr[s*ADDR_W +: ADDR_W]       = master_addr[i*ADDR_W +: ADDR_W];
          slave_wdata[s*DATA_W +: DATA_W]      = master_wdata[i*DATA_W +: DATA_W];
          master_ack[i]                        = master_ack[i] | slave_ack[s];
        end
        if (rd_pend[s] && rd_owner[s] == MidW'(i)) begin
          master_rdata[i*DATA_W +: DATA_W] = master_rdata[i*DATA_W +: DATA_W]
                                           | slave_rdata[s*DATA_W +: DATA_W];
        end
      end
    end
    if (!reset) begin
      slave_req    = '0;
      slave_cmd    = '0;
      slave_addr   = '0;
      slave_wdata  = '0;
      master_ack   = '0;
      master_rdata = '0;
    end
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// tb_crossbar_nxm: directed bench for crossbar_nxm with a transaction-level
// reference model compared on every falling edge, plus literal expectations.
module tb_crossbar_nxm;

  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clock;
  logic              reset;
  logic [NM-1:0]     master_req, master_cmd, master_ack;
  logic [NM*AW-1:0]  master_addr;
  logic [NM*DW-1:0]  master_wdata, master_rdata;
  logic [NS-1:0]     slave_req, slave_cmd, slave_ack;
  logic [NS*AW-1:0]  slave_addr;
  logic [NS*DW-1:0]  slave_wdata, slave_rdata;

  logic [NS-1:0]     ack_en, force_ack;
  logic [NM-1:0]     acked_last;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                ack_q[$];
  int                ack_cyc[$];

  crossbar_nxm #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .master_req   (master_req),
    .master_cmd   (master_cmd),
    .master_addr  (master_addr),
    .master_wdata (master_wdata),
    .master_ack   (master_ack),
    .master_rdata (master_rdata),
    .slave_req    (slave_req),
    .slave_cmd    (slave_cmd),
    .slave_addr   (slave_addr),
    .slave_wdata  (slave_wdata),
    .slave_ack    (slave_ack),
    .slave_rdata  (slave_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_owner [NS] = '{default: -1};
  int m_ptr   [NS] = '{default: 0};
  int m_rd    [NS] = '{default: -1};
  bit m_taken [NM];
  int m_pick, m_cand, m_nrd;

  function automatic int tgt_of(input int i);
    logic [AW-1:0] a;
    a = master_addr[i*AW +: AW];
    return int'(a >> (AW - SW));
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        m_owner[s] = -1; m_ptr[s] = 0; m_rd[s] = -1;
      end
    end else begin
      for (int i = 0; i < NM; i++) m_taken[i] = 1'b0;
      for (int s = 0; s < NS; s++) if (m_owner[s] >= 0) m_taken[m_owner[s]] = 1'b1;
      for (int s = 0; s < NS; s++) begin
        m_nrd = -1;
        if (m_owner[s] >= 0) begin
          if (slave_ack[s]) begin
            if (master_cmd[m_owner[s]] == 1'b0) m_nrd = m_owner[s];
            m_ptr[s]   = (m_owner[s] + 1) % NM;
            m_owner[s] = -1;
          end
        end else begin
          m_pick = -1;
          for (int k = 0; k < NM; k++) begin
            m_cand = (m_ptr[s] + k) % NM;
            if (m_pick < 0 && master_req[m_cand] && tgt_of(m_cand) == s && !m_taken[m_cand])
              m_pick = m_cand;
          end
          m_owner[s] = m_pick;
        end
        m_rd[s] = m_nrd;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  int          c_o;
  logic        c_ack;
  logic [31:0] c_rd;

  always @(negedge clock) begin
    for (int s = 0; s < NS; s++) begin
      c_o = m_owner[s];
      if (reset && c_o >= 0) begin
        check($sformatf("slave_req[%0d]", s), slave_req[s], 1);
        check($sformatf("slave_cmd[%0d]", s), slave_cmd[s], master_cmd[c_o]);
        check($sformatf("slave_addr[%0d]", s), slave_addr[s*AW +: AW], master_addr[c_o*AW +: AW]);
        check($sformatf("slave_wdata[%0d]", s), slave_wdata[s*DW +: DW], master_wdata[c_o*DW +: DW]);
        check($sformatf("req_held[%0d]", c_o), master_req[c_o], 1);
      end else begin
        check($sformatf("slave_req[%0d]", s), slave_req[s], 0);
        check($sformatf("slave_cmd[%0d]", s), slave_cmd[s], 0);
        check($sformatf("slave_addr[%0d]", s), slave_addr[s*AW +: AW], 0);
        check($sformatf("slave_wdata[%0d]", s), slave_wdata[s*DW +: DW], 0);
      end
    end
    for (int i = 0; i < NM; i++) begin
      c_ack = 1'b0;
      c_rd  = '0;
      for (int s = 0; s < NS; s++) begin
        if (reset && m_owner[s] == i && slave_ack[s]) c_ack = 1'b1;
        if (reset && m_rd[s] == i) c_rd = slave_rdata[s*DW +: DW];
      end
      check($sformatf("master_ack[%0d]", i), master_ack[i], c_ack);
      check($sformatf("master_rdata[%0d]", i), master_rdata[i*DW +: DW], c_rd);
    end
  end

  // Ack log for ordering checks; also feeds the masters' drop-after-ack.
  always @(negedge clock) begin
    acked_last = master_ack;
    for (int i = 0; i < NM; i++) begin
      if (master_ack[i]) begin
        ack_q.push_back(i);
        ack_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input int i, input logic req, input logic cmd,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    master_req[i]           = req;
    master_cmd[i]           = cmd;
    master_addr[i*AW +: AW] = addr;
    master_wdata[i*DW +: DW] = wd;
  endtask

  // Start of a cycle: masters drop requests that were acknowledged last cycle.
  task automatic step();
    @(posedge clock);
    #1;
    master_req = master_req & ~acked_last;
  endtask

  // Slave responder, then settle for literal checks before the falling edge.
  task automatic go();
    #1;
    slave_ack = (ack_en & slave_req) | force_ack;
    #2;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b0;
    master_req = '0; master_cmd = '0; master_addr = '0; master_wdata = '0;
    ack_en = '0; force_ack = '0;
    go();
    step();
    reset = 1'b1;
    ack_q.delete();
    ack_cyc.delete();
    go();
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    master_req = '0; master_cmd = '0; master_addr = '0; master_wdata = '0;
    slave_ack = '0; slave_rdata = '0; ack_en = '0; force_ack = '0; acked_last = '0;

    // Reset state
    apply_reset();
    check("reset_slave_req", slave_req, 0);
    check("reset_master_ack", master_ack, 0);
    check("reset_master_rdata", master_rdata == '0, 1);

    // Single write M0 -> S1
    step(); set_m(0, 1, 1, 32'h4000_0010, 32'hDEAD_BEEF); go();
    check("wr_c0_sreq", slave_req[1], 0);
    step(); go();
    check("wr_c1_sreq", slave_req[1], 1);
    check("wr_c1_addr", slave_addr[1*AW +: AW], 32'h4000_0010);
    check("wr_c1_wdata", slave_wdata[1*DW +: DW], 32'hDEAD_BEEF);
    check("wr_c1_cmd", slave_cmd[1], 1);
    check("wr_c1_noack", master_ack[0], 0);
    step(); ack_en[1] = 1'b1; go();
    check("wr_ack", master_ack[0], 1);
    step(); ack_en[1] = 1'b0; go();
    check("wr_idle", slave_req[1], 0);

    // Read return M2 -> S3
    step(); slave_rdata[3*DW +: DW] = 32'h1234_5678; ack_en[3] = 1'b1;
    set_m(2, 1, 0, 32'hC000_0000, 32'h0); go();
    step(); go();
    check("rd_ack", master_ack[2], 1);
    check("rd_c1_rdata", master_rdata[2*DW +: DW], 0);
    step(); go();
    check("rd_return", master_rdata[2*DW +: DW], 32'h1234_5678);
    step(); ack_en[3] = 1'b0; go();
    check("rd_after", master_rdata[2*DW +: DW], 0);

    // slave_ack while idle is ignored
    step(); force_ack = '1; go();
    check("idle_ack_ignored", master_ack, 0);
    step(); force_ack = '0; go();
    check("idle_no_rdata", master_rdata == '0, 1);

    // Round-robin contention on S0
    apply_reset();
    step();
    ack_en[0] = 1'b1;
    for (int i = 0; i < NM; i++) set_m(i, 1, 1, 32'(i * 16), 32'(i + 1));
    go();
    for (int k = 0; k < 30 && ack_q.size() < 5; k++) begin
      step();
      if (k == 1) master_req[0] = 1'b1;
      go();
    end
    check("rr_ack_count", ack_q.size(), 5);
    if (ack_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_order[%0d]", k), ack_q[k], exp_rr[k]);
      for (int k = 1; k < 5; k++) check($sformatf("rr_gap[%0d]", k), ack_cyc[k] - ack_cyc[k-1], 2);
    end
    step(); ack_en[0] = 1'b0; go();

    // Parallel masters on different slaves
    apply_reset();
    step(); set_m(0, 1, 1, 32'h0000_0100, 32'h1111_1111);
    set_m(1, 1, 1, 32'h8000_0200, 32'h2222_2222); go();
    step(); go();
    check("par_sreq0", slave_req[0], 1);
    check("par_sreq2", slave_req[2], 1);
    check("par_addr0", slave_addr[0 +: AW], 32'h0000_0100);
    check("par_addr2", slave_addr[2*AW +: AW], 32'h8000_0200);
    step(); ack_en[2] = 1'b1; go();
    check("par_ack_s2", master_ack, 4'b0010);
    step(); ack_en[2] = 1'b0; ack_en[0] = 1'b1; go();
    check("par_ack_s0", master_ack, 4'b0001);
    check("par_s2_idle", slave_req[2], 0);
    step(); ack_en[0] = 1'b0; go();

    // Reset mid-operation: S1 read pending, S3 busy
    apply_reset();
    step(); slave_rdata[1*DW +: DW] = 32'h5A5A_5A5A; ack_en[1] = 1'b1;
    set_m(1, 1, 0, 32'h4000_0000, 32'h0);
    set_m(2, 1, 1, 32'hC000_0004, 32'h0000_0033); go();
    step(); go();
    check("rst_pre_ack", master_ack[1], 1);
    check("rst_pre_s3busy", slave_req[3], 1);
    step(); reset = 1'b0;
    master_req = '0; master_cmd = '0; master_addr = '0; master_wdata = '0;
    ack_en = '0; force_ack[3] = 1'b1; go();
    check("rst_no_ack", master_ack, 0);
    check("rst_no_rdata", master_rdata == '0, 1);
    step(); reset = 1'b1; force_ack = '0; ack_q.delete(); ack_cyc.delete();
    ack_en[1] = 1'b1;
    set_m(1, 1, 1, 32'h4000_0008, 32'h0000_0001);
    set_m(3, 1, 1, 32'h4000_000C, 32'h0000_0003); go();
    check("rst_out_req", slave_req, 0);
    check("rst_out_ack", master_ack, 0);
    check("rst_out_rdata", master_rdata == '0, 1);
    for (int k = 0; k < 20 && ack_q.size() < 2; k++) begin
      step(); go();
    end
    check("rst_ptr_count", ack_q.size(), 2);
    if (ack_q.size() >= 2) begin
      check("rst_ptr_first", ack_q[0], 1);
      check("rst_ptr_second", ack_q[1], 3);
    end
    step(); ack_en = '0; go();

    // Grant overlapping a read return on S0
    apply_reset();
    step(); slave_rdata[0 +: DW] = 32'hA5A5_0001; ack_en[0] = 1'b1;
    set_m(1, 1, 0, 32'h0000_0040, 32'h0);
    set_m(3, 1, 1, 32'h0000_0080, 32'h0000_0077); go();
    step(); go();
    check("ovl_ack_m1", master_ack[1], 1);
    step(); go();
    check("ovl_rdata_m1", master_rdata[1*DW +: DW], 32'hA5A5_0001);
    check("ovl_rdata_m3", master_rdata[3*DW +: DW], 0);
    check("ovl_bubble", slave_req[0], 0);
    step(); slave_rdata[0 +: DW] = 32'hFFFF_0000; go();
    check("ovl_sreq", slave_req[0], 1);
    check("ovl_addr", slave_addr[0 +: AW], 32'h0000_0080);
    check("ovl_ack_m3", master_ack[3], 1);
    check("ovl_rdata_done", master_rdata[1*DW +: DW], 0);
    step(); ack_en = '0; go();
    step(); go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
